insert_repair_scheduler: RTL and testbench

- Sequencer that repairs an N-digit DNA word known to have suffered one deletion.
- Sweeps every (missing_index, missing_digit) candidate through the shared insert_digit datapath, which has a 1-cycle registered latency.
- Offers each N+1-digit candidate to an external codeword checker over a valid/ready handshake, and stops at the first candidate the checker accepts or when all candidates are exhausted.

---
 rtl/insert_repair_scheduler_if.sv | 38 +++
 rtl/insert_repair_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_insert_repair_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/insert_repair_scheduler_if.sv
// Bus between insert_repair_scheduler, the shared insert_digit datapath and the
// external codeword checker. master = scheduler side, slave = environment side.
interface insert_repair_scheduler_if #(
  parameter int N = 6
);
  logic             start;
  logic [2*N-1:0]   word_in;
  logic             busy;

  logic [2*N-1:0]   dp_word_in;
  logic [6:0]       dp_missing_index;
  logic [1:0]       dp_missing_digit;
  logic [2*N+1:0]   dp_word_out;

  logic             cand_valid;
  logic [2*N+1:0]   cand_word;
  logic             cand_ready;
  logic             chk_valid;
  logic             chk_pass;

  logic             done;
  logic             found;
  logic [2*N+1:0]   fix_word;
  logic [6:0]       fix_index;
  logic [1:0]       fix_digit;

  modport master (
    input  start, word_in, dp_word_out, cand_ready, chk_valid, chk_pass,
    output busy, dp_word_in, dp_missing_index, dp_missing_digit,
           cand_valid, cand_word, done, found, fix_word, fix_index, fix_digit
  );

  modport slave (
    output start, word_in, dp_word_out, cand_ready, chk_valid, chk_pass,
    input  busy, dp_word_in, dp_missing_index, dp_missing_digit,
           cand_valid, cand_word, done, found, fix_word, fix_index, fix_digit
  );
endinterface

// File: rtl/insert_repair_scheduler.sv
// Sweeps (missing_index, missing_digit) candidates through insert_digit and offers
// each to a checker. Define INSERT_REPAIR_SKIP_DUP_EN to skip duplicate candidates.
module insert_repair_scheduler #(
  parameter int N = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  insert_repair_scheduler_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    LOAD,
    OFFER,
    WAIT_CHK,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [2*N-1:0]  word_q;
  logic [6:0]      idx;
  logic [1:0]      digit;
  logic [2*N+1:0]  cand_word_q;
  logic            found_q;
  logic [2*N+1:0]  fix_word_q;
  logic [6:0]      fix_index_q;
  logic [1:0]      fix_digit_q;

  logic            start_take;
  logic            load_cand;
  logic            pass_take;
  logic            fail_end;
  logic            step;

  logic            has_next;
  logic [6:0]      next_idx;
  logic [1:0]      next_digit;

  logic            skip_d1;
  logic            skip_d2;
  logic            skip_n0;

`ifdef INSERT_REPAIR_SKIP_DUP_EN
  logic [1:0]      dig_here;
  logic [1:0]      dig_next;

  // Received digit at position N-1-idx for the current and the following index.
  always_comb begin
    dig_here = 2'd0;
    dig_next = 2'd0;
    for (int k = 0; k < N; k++) begin
      if (idx == 7'(k))
        dig_here = word_q[2*(N-1-k) +: 2];
      if (idx + 7'd1 == 7'(k))
        dig_next = word_q[2*(N-1-k) +: 2];
    end
  end

  assign skip_d1 = (idx != 7'd0) && (({1'b0, digit} + 3'd1) == {1'b0, dig_here});
  assign skip_d2 = (idx != 7'd0) && (({1'b0, digit} + 3'd2) == {1'b0, dig_here});
  assign skip_n0 = (dig_next == 2'd0);
`else
  assign skip_d1 = 1'b0;
  assign skip_d2 = 1'b0;
  assign skip_n0 = 1'b0;
`endif

  // At most one digit per index is skipped, so looking two steps ahead always suffices.
  always_comb begin
    has_next   = 1'b1;
    next_idx   = idx;
    next_digit = digit;
    if (digit <= 2'd2 && !skip_d1) begin
      next_digit = digit + 2'd1;
    end else if (digit <= 2'd1 && !skip_d2) begin
      next_digit = digit + 2'd2;
    end else if (idx < 7'(N-1)) begin
      next_idx   = idx + 7'd1;
      next_digit = skip_n0 ? 2'd1 : 2'd0;
    end else begin
      has_next   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_take = 1'b0;
    load_cand  = 1'b0;
    pass_take  = 1'b0;
    fail_end   = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          start_take = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = LOAD;
      LOAD: begin
        load_cand  = 1'b1;
        state_next = OFFER;
      end
      OFFER: begin
        if (bus.cand_ready)
          state_next = WAIT_CHK;
      end
      WAIT_CHK: begin
        if (bus.chk_valid) begin
          if (bus.chk_pass) begin
            pass_take  = 1'b1;
            state_next = DONE;
          end else if (!has_next) begin
            fail_end   = 1'b1;
            state_next = DONE;
          end else begin
            step       = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Candidate registers double as the dp_* outputs, so insert_digit sees them directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      idx         <= '0;
      digit       <= '0;
      cand_word_q <= '0;
      found_q     <= 1'b0;
      fix_word_q  <= '0;
      fix_index_q <= '0;
      fix_digit_q <= '0;
    end else begin
      if (start_take) begin
        word_q      <= bus.word_in;
        idx         <= '0;
        digit       <= '0;
        found_q     <= 1'b0;
        fix_word_q  <= '0;
        fix_index_q <= '0;
        fix_digit_q <= '0;
      end
      if (load_cand)
        cand_word_q <= bus.dp_word_out;
      if (step) begin
        idx   <= next_idx;
        digit <= next_digit;
      end
      if (pass_take) begin
        found_q     <= 1'b1;
        fix_word_q  <= cand_word_q;
        fix_index_q <= idx;
        fix_digit_q <= digit;
      end
      if (fail_end) begin
        found_q     <= 1'b0;
        fix_word_q  <= '0;
        fix_index_q <= '0;
        fix_digit_q <= '0;
      end
    end
  end

  assign bus.busy             = (state != IDLE);
  assign bus.cand_valid       = (state == OFFER);
  assign bus.done             = (state == DONE);
  assign bus.cand_word        = cand_word_q;
  assign bus.dp_word_in       = word_q;
  assign bus.dp_missing_index = idx;
  assign bus.dp_missing_digit = digit;
  assign bus.found            = found_q;
  assign bus.fix_word         = fix_word_q;
  assign bus.fix_index        = fix_index_q;
  assign bus.fix_digit        = fix_digit_q;

endmodule

// File: tb/tb_insert_repair_scheduler.sv
// Randomized bench for insert_repair_scheduler with a stand-in insert_digit and a
// queue-based model of the candidate order, offer contents and final result.
module tb_insert_repair_scheduler;

  localparam int N  = 6;
  localparam int W  = 2*N;
  localparam int WO = 2*N+2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dp_reset;

  int checks = 0;
  int errors = 0;
  int plan[$];

  always #5 clk = ~clk;

  insert_repair_scheduler_if #(.N(N)) bus();

  insert_repair_scheduler #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Digit at MSB-side position 'at' of the N+1 digit result is 'd'.
  function automatic logic [WO-1:0] insert_model(input logic [W-1:0] w, input int at, input int d);
    logic [1:0]    digs[$];
    logic [WO-1:0] r;
    for (int k = 0; k < N; k++)
      digs.push_back(w[2*(N-1-k) +: 2]);
    digs.insert(at, 2'(d));
    r = '0;
    for (int k = 0; k <= N; k++)
      r[2*(N-k) +: 2] = digs[k];
    return r;
  endfunction

  // Stand-in insert_digit: one registered cycle, active-high reset from ~rst_n.
  assign dp_reset = ~rst_n;
  always @(posedge clk or posedge dp_reset) begin
    if (dp_reset)
      bus.dp_word_out <= '0;
    else if (int'(bus.dp_missing_index) <= N)
      bus.dp_word_out <= insert_model(bus.dp_word_in, int'(bus.dp_missing_index), int'(bus.dp_missing_digit));
    else
      bus.dp_word_out <= '0;
  end

  // Candidate order as pair codes idx*4+digit.
  function automatic void build_plan(input logic [W-1:0] w);
    bit skip;
    plan.delete();
    for (int i = 0; i < N; i++) begin
      for (int d = 0; d < 4; d++) begin
        skip = 1'b0;
`ifdef INSERT_REPAIR_SKIP_DUP_EN
        skip = (i >= 1) && (int'(w[2*(N-1-i) +: 2]) == d);
`endif
        if (!skip)
          plan.push_back(i*4 + d);
      end
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_busy"},       64'(bus.busy), 64'd0);
    checkOutput({tag, "_cand_valid"}, 64'(bus.cand_valid), 64'd0);
    checkOutput({tag, "_done"},       64'(bus.done), 64'd0);
    checkOutput({tag, "_found"},      64'(bus.found), 64'd0);
    checkOutput({tag, "_fix_word"},   64'(bus.fix_word), 64'd0);
    checkOutput({tag, "_fix_index"},  64'(bus.fix_index), 64'd0);
    checkOutput({tag, "_fix_digit"},  64'(bus.fix_digit), 64'd0);
    checkOutput({tag, "_cand_word"},  64'(bus.cand_word), 64'd0);
    checkOutput({tag, "_dp_word_in"}, 64'(bus.dp_word_in), 64'd0);
    checkOutput({tag, "_dp_index"},   64'(bus.dp_missing_index), 64'd0);
    checkOutput({tag, "_dp_digit"},   64'(bus.dp_missing_digit), 64'd0);
  endtask

  // One repair: target is the only pair code the checker accepts (-1 = never).
  task automatic applyStimulus(input logic [W-1:0] w, input int target, input int stall_first,
                               input bit noise, input int abort_at);
    int  exp_offers;
    bit  exp_found;
    int  offers;
    int  stall;
    int  delay;
    int  pair;
    int  last_pair;
    bit  in_offer;
    bit  wait_verdict;
    bit  seen_valid;
    bit  finished;

    build_plan(w);
    exp_offers = plan.size();
    exp_found  = 1'b0;
    foreach (plan[k]) begin
      if (!exp_found && plan[k] == target) begin
        exp_found  = 1'b1;
        exp_offers = k + 1;
      end
    end

    offers = 0; stall = 0; delay = 0; last_pair = -1;
    in_offer = 1'b0; wait_verdict = 1'b0; seen_valid = 1'b0; finished = 1'b0;

    @(negedge clk);
    bus.word_in = w;
    bus.start   = 1'b1;
    @(negedge clk);

    for (int cyc = 1; cyc <= 1500 && !finished; cyc++) begin
      bus.start      = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.word_in    = W'($urandom());
      bus.cand_ready = 1'b0;
      bus.chk_valid  = 1'b0;
      bus.chk_pass   = 1'b0;
      if (cyc == 1)
        checkOutput("busy_after_start", 64'(bus.busy), 64'd1);

      if (bus.done) begin
        finished = 1'b1;
        checkOutput("offer_count", 64'(offers), 64'(exp_offers));
        checkOutput("found", 64'(bus.found), 64'(exp_found));
        checkOutput("fix_word", 64'(bus.fix_word),
                    exp_found ? 64'(insert_model(w, target / 4, target % 4)) : 64'd0);
        checkOutput("fix_index", 64'(bus.fix_index), exp_found ? 64'(target / 4) : 64'd0);
        checkOutput("fix_digit", 64'(bus.fix_digit), exp_found ? 64'(target % 4) : 64'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("busy_after_done", 64'(bus.busy), 64'd0);
        checkOutput("done_one_cycle", 64'(bus.done), 64'd0);
        @(negedge clk);
        checkOutput("start_in_done_ignored", 64'(bus.busy), 64'd0);
        checkOutput("found_hold", 64'(bus.found), 64'(exp_found));
      end else if (bus.cand_valid) begin
        if (!seen_valid) begin
          seen_valid = 1'b1;
          checkOutput("first_valid_latency", 64'(cyc), 64'd3);
        end
        if (offers < plan.size()) begin
          pair = plan[offers];
        end else begin
          checkOutput("extra_offer", 64'(offers), 64'(plan.size()));
          pair = 0;
        end
        checkOutput("cand_word", 64'(bus.cand_word), 64'(insert_model(w, pair / 4, pair % 4)));
        checkOutput("dp_index", 64'(bus.dp_missing_index), 64'(pair / 4));
        checkOutput("dp_digit", 64'(bus.dp_missing_digit), 64'(pair % 4));
        checkOutput("dp_word_in", 64'(bus.dp_word_in), 64'(w));
        if (!in_offer) begin
          in_offer = 1'b1;
          stall    = (offers == 0) ? stall_first : int'($urandom_range(0, 2));
        end
        if (stall > 0) begin
          stall--;
          if (noise) begin
            bus.chk_valid = 1'($urandom_range(0, 1));
            bus.chk_pass  = 1'b1;
          end
        end else begin
          bus.cand_ready = 1'b1;
          in_offer       = 1'b0;
          wait_verdict   = 1'b1;
          offers++;
          last_pair      = pair;
          delay          = int'($urandom_range(0, 3));
        end
      end else if (wait_verdict) begin
        if (abort_at == offers) begin
          rst_n = 1'b0;
          #1;
          check_reset_outputs("abort");
          @(negedge clk);
          checkOutput("abort_no_done", 64'(bus.done), 64'd0);
          rst_n = 1'b1;
          bus.start = 1'b0;
          return;
        end
        if (delay == 0) begin
          bus.chk_valid = 1'b1;
          bus.chk_pass  = (last_pair == target);
          wait_verdict  = 1'b0;
        end else begin
          delay--;
        end
      end
      if (!finished)
        @(negedge clk);
    end

    if (!finished)
      checkOutput("timeout", 64'd1, 64'd0);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rw;
    bus.start      = 1'b0;
    bus.word_in    = '0;
    bus.cand_ready = 1'b0;
    bus.chk_valid  = 1'b0;
    bus.chk_pass   = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(12'h1B1, 2*4 + 3, 0, 1'b0, -1);
    applyStimulus(12'h1B1, -1, 0, 1'b0, -1);
    applyStimulus(W'($urandom()), int'($urandom_range(0, 23)), 5, 1'b0, -1);
    applyStimulus(W'($urandom()), -1, 0, 1'b0, 7);
    applyStimulus(12'h2C7, 3*4 + 1, 0, 1'b0, -1);
    applyStimulus(W'($urandom()), int'($urandom_range(0, 23)), 2, 1'b1, -1);
    applyStimulus(12'h000, -1, 0, 1'b0, -1);
    for (int r = 0; r < 6; r++) begin
      rw = W'($urandom());
      applyStimulus(rw, int'($urandom_range(0, 24)) - 1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
